// File: rtl/grid_pkg.sv
// Shared grid definitions: cell function codes, default board geometry,
// the arbiter state type and a coordinate range helper.
package grid_pkg;

  localparam logic [3:0] CELL_EMPTY = 4'd0;
  localparam logic [3:0] CELL_HEAD  = 4'd1;
  localparam logic [3:0] CELL_BODY  = 4'd2;
  localparam logic [3:0] CELL_FOOD  = 4'd3;
  localparam logic [3:0] CELL_WALL  = 4'd4;

  localparam int GRID_W_DEF = 32;
  localparam int GRID_H_DEF = 24;
  localparam int XW_DEF     = 5;
  localparam int YW_DEF     = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1
  } arb_state_t;

  function automatic logic in_grid(input int unsigned x, input int unsigned y,
                                   input int unsigned w, input int unsigned h);
    return (x < w) && (y < h);
  endfunction

endpackage

// File: rtl/grid_port_arbiter_if.sv
// Requester-side and grid_register-side signals of the cell port arbiter.
interface grid_port_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int XW    = 5,
  parameter int YW    = 5
);

  // Handshake: a requester raises req[i] with req_we/req_x/req_y/req_wdata
  // and holds them stable until it sees the one-cycle gnt[i] pulse; it may
  // drop or change them from the cycle after gnt. Reads return later as a
  // one-cycle rvalid[i] pulse qualifying the shared rdata. err[i] pulses with
  // gnt[i] when the coordinate is off the board.
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    req_we;
  logic [N_REQ*XW-1:0] req_x;
  logic [N_REQ*YW-1:0] req_y;
  logic [N_REQ*4-1:0]  req_wdata;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    rvalid;
  logic [3:0]          rdata;
  logic [N_REQ-1:0]    err;

  logic                grid_we;
  logic                grid_re;
  logic [XW-1:0]       grid_x;
  logic [YW-1:0]       grid_y;
  logic [3:0]          grid_wdata;
  logic [3:0]          grid_rdata;

  modport master (
    output req, req_we, req_x, req_y, req_wdata, grid_rdata,
    input  gnt, rvalid, rdata, err,
    input  grid_we, grid_re, grid_x, grid_y, grid_wdata
  );

  modport slave (
    input  req, req_we, req_x, req_y, req_wdata, grid_rdata,
    output gnt, rvalid, rdata, err,
    output grid_we, grid_re, grid_x, grid_y, grid_wdata
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible requester at or after ptr,
// wrapping around; reports the winner one-hot, as an index, and a valid flag.
module rr_arbiter
  import grid_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          valid
);

  int cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = 0;
    for (int off = 0; off < N; off++) begin
      cand = int'(ptr) + off;
      if (cand >= N) cand = cand - N;
      if (!valid && elig[cand]) begin
        valid        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/grid_port_arbiter.sv
// Round-robin arbiter sharing the single grid_register cell port between
// game requesters, with optional confinement of writes to vertical blanking.
module grid_port_arbiter
  import grid_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int XW           = XW_DEF,
  parameter int YW           = YW_DEF,
  parameter int GRID_W       = GRID_W_DEF,
  parameter int GRID_H       = GRID_H_DEF,
  parameter int READ_LATENCY = 1,
  parameter int VBLANK_LOCK  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk_in,
  grid_port_arbiter_if.slave bus,
  output arb_state_t dbg_state
);

  localparam int         PW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [1:0] RL_LAST = 2'(READ_LATENCY);

  arb_state_t       state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    owner;
  logic [1:0]       cnt;
  logic             rd_err;

  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] err_q;
  logic [N_REQ-1:0] rvalid_q;
  logic [3:0]       rdata_q;
  logic             grid_we_q;
  logic             grid_re_q;
  logic [XW-1:0]    grid_x_q;
  logic [YW-1:0]    grid_y_q;
  logic [3:0]       grid_wdata_q;

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] win_oh;
  logic [PW-1:0]    win_idx;
  logic             win_valid;

  logic             sel_we;
  logic [XW-1:0]    sel_x;
  logic [YW-1:0]    sel_y;
  logic [3:0]       sel_wdata;
  logic             sel_oor;
  logic [PW-1:0]    next_ptr;
  logic             rd_done;

  // The blanking lock only gates writes; a blocked write stays pending and
  // simply drops out of this cycle's search so reads behind it still win.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = bus.req[i] && (!bus.req_we[i] || (VBLANK_LOCK == 0) || vblnk_in);
    end
  end

  rr_arbiter #(
    .N  (N_REQ),
    .PW (PW)
  ) u_rr (
    .elig   (elig),
    .ptr    (ptr),
    .onehot (win_oh),
    .idx    (win_idx),
    .valid  (win_valid)
  );

  always_comb begin
    sel_we    = bus.req_we[win_idx];
    sel_x     = bus.req_x[int'(win_idx)*XW +: XW];
    sel_y     = bus.req_y[int'(win_idx)*YW +: YW];
    sel_wdata = bus.req_wdata[int'(win_idx)*4 +: 4];
    sel_oor   = !in_grid(32'(sel_x), 32'(sel_y), GRID_W, GRID_H);
    next_ptr  = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
    // Off-board reads never touch grid_register, so they answer immediately.
    rd_done   = rd_err ? (cnt == 2'd0) : (cnt == RL_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      owner        <= '0;
      cnt          <= '0;
      rd_err       <= 1'b0;
      gnt_q        <= '0;
      err_q        <= '0;
      rvalid_q     <= '0;
      rdata_q      <= '0;
      grid_we_q    <= 1'b0;
      grid_re_q    <= 1'b0;
      grid_x_q     <= '0;
      grid_y_q     <= '0;
      grid_wdata_q <= '0;
    end else begin
      gnt_q     <= '0;
      err_q     <= '0;
      rvalid_q  <= '0;
      grid_we_q <= 1'b0;
      grid_re_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            gnt_q <= win_oh;
            ptr   <= next_ptr;
            if (sel_oor) err_q <= win_oh;
            if (sel_we) begin
              if (!sel_oor) begin
                grid_we_q    <= 1'b1;
                grid_x_q     <= sel_x;
                grid_y_q     <= sel_y;
                grid_wdata_q <= sel_wdata;
              end
            end else begin
              if (!sel_oor) begin
                grid_re_q <= 1'b1;
                grid_x_q  <= sel_x;
                grid_y_q  <= sel_y;
              end
              owner  <= win_idx;
              rd_err <= sel_oor;
              cnt    <= '0;
              state  <= ST_RD_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          if (rd_done) begin
            rvalid_q[owner] <= 1'b1;
            rdata_q         <= rd_err ? CELL_EMPTY : bus.grid_rdata;
            state           <= ST_IDLE;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.err        = err_q;
  assign bus.rvalid     = rvalid_q;
  assign bus.rdata      = rdata_q;
  assign bus.grid_we    = grid_we_q;
  assign bus.grid_re    = grid_re_q;
  assign bus.grid_x     = grid_x_q;
  assign bus.grid_y     = grid_y_q;
  assign bus.grid_wdata = grid_wdata_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_grid_port_arbiter.sv
// Scoreboard bench for grid_port_arbiter: directed transactions push expected
// grant and read responses; a monitor pops and compares on every DUT pulse.
module tb_grid_port_arbiter;
  import grid_pkg::*;

  localparam int N  = 2;
  localparam int XW = 6;
  localparam int YW = 5;
  localparam int RL = 2;
  localparam int GW = 22;
  localparam int RW = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vblnk = 1'b0;
  arb_state_t dbg_state;

  grid_port_arbiter_if #(.N_REQ(N), .XW(XW), .YW(YW)) bus ();

  grid_port_arbiter #(
    .N_REQ(N), .XW(XW), .YW(YW), .GRID_W(32), .GRID_H(24),
    .READ_LATENCY(RL), .VBLANK_LOCK(1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .vblnk_in  (vblnk),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // grid_register model: data for a read strobed in cycle t is valid in t+RL
  logic [3:0] mem  [0:63][0:31];
  logic [3:0] pipe [0:RL-1];
  always @(posedge clk) begin
    if (!rst) begin
      mem[5][6]  <= CELL_FOOD;
      mem[9][10] <= CELL_WALL;
    end else if (bus.grid_we) begin
      mem[bus.grid_x][bus.grid_y] <= bus.grid_wdata;
    end
    pipe[0] <= mem[bus.grid_x][bus.grid_y];
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.grid_rdata = pipe[RL-1];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_gnt = 0;
  int n_gnt0 = 0;
  int n_gnt1 = 0;
  int gnt_cyc = 0;
  logic rd_pending = 1'b0;
  logic [GW-1:0] exp_gnt_q[$];
  logic [RW-1:0] exp_rd_q[$];

  function automatic logic [GW-1:0] mk_gnt(logic rd, logic [1:0] g, logic [1:0] e,
      logic we, logic re, logic [5:0] x, logic [4:0] y, logic [3:0] wd);
    return {rd, g, e, we, re, x, y, wd};
  endfunction

  function automatic logic [RW-1:0] mk_rd(int lat, logic [1:0] rv, logic [3:0] d);
    return {4'(lat), rv, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [5:0] x,
                         input logic [4:0] y, input logic [3:0] wd);
    bus.req_we[i]              = we;
    bus.req_x[i*XW +: XW]      = x;
    bus.req_y[i*YW +: YW]      = y;
    bus.req_wdata[i*4 +: 4]    = wd;
    bus.req[i]                 = 1'b1;
  endtask

  task automatic wait_gnts(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (n_gnt < target && k < budget) begin
      tick();
      k++;
    end
    if (n_gnt < target) check(name, n_gnt, target);
  endtask

  task automatic wait_read_done(input int budget);
    int k;
    k = 0;
    while ((rd_pending || exp_rd_q.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    if (rd_pending || exp_rd_q.size() != 0) check("read_timeout", exp_rd_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {bus.gnt, bus.rvalid, bus.err, bus.grid_we, bus.grid_re,
                 bus.grid_x, bus.grid_y, bus.grid_wdata, bus.rdata}, 0);
    check("state_idle", dbg_state, ST_IDLE);
  endtask

  // Monitor: every grant and every read response is matched against the queues
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    logic [GW-1:0] e;
    logic [RW-1:0] r;
    @(negedge clk);
    if (!rst) begin
      rd_pending = 1'b0;
    end else begin
      if (bus.gnt != 0) begin
        n_gnt++;
        if (bus.gnt[0]) n_gnt0++;
        if (bus.gnt[1]) n_gnt1++;
        if (rd_pending) check("gnt_during_read", 1, 0);
        if (exp_gnt_q.size() == 0) begin
          check("unexpected_gnt", {bus.gnt, bus.err, bus.grid_we, bus.grid_re}, 0);
        end else begin
          e = exp_gnt_q.pop_front();
          check("gnt_outputs", {bus.gnt, bus.err, bus.grid_we, bus.grid_re,
                                bus.grid_x, bus.grid_y, bus.grid_wdata}, e[20:0]);
          if (e[21]) begin
            rd_pending = 1'b1;
            gnt_cyc    = cyc;
          end
        end
      end
      if (bus.rvalid != 0) begin
        if (exp_rd_q.size() == 0) begin
          check("unexpected_rvalid", {bus.rvalid, bus.rdata}, 0);
        end else begin
          r = exp_rd_q.pop_front();
          check("rvalid_rdata", {bus.rvalid, bus.rdata}, r[5:0]);
          check("read_turnaround", cyc - gnt_cyc, r[9:6]);
        end
        rd_pending = 1'b0;
      end
    end
  end

  initial begin
    int base, b0, b1, k;
    bus.req = '0; bus.req_we = '0; bus.req_x = '0; bus.req_y = '0; bus.req_wdata = '0;
    repeat (3) tick();
    check_outputs_zero("reset_outputs");
    rst = 1'b1;
    tick();
    check_outputs_zero("post_reset_idle");

    // single in-range write
    vblnk = 1'b1;
    exp_gnt_q.push_back(mk_gnt(0, 2'b01, 2'b00, 1, 0, 3, 4, CELL_BODY));
    base = n_gnt;
    set_req(0, 1, 3, 4, CELL_BODY);
    wait_gnts(base + 1, 20, "t1_gnt_timeout");
    bus.req[0] = 1'b0;
    repeat (2) tick();

    // read with latency 2: rvalid three cycles after gnt
    exp_gnt_q.push_back(mk_gnt(1, 2'b10, 2'b00, 0, 1, 5, 6, CELL_BODY));
    exp_rd_q.push_back(mk_rd(3, 2'b10, CELL_FOOD));
    base = n_gnt;
    set_req(1, 0, 5, 6, 0);
    wait_gnts(base + 1, 20, "t2_gnt_timeout");
    bus.req[1] = 1'b0;
    wait_read_done(20);
    repeat (2) tick();

    // fairness: both requesters write continuously for 20 grants
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) exp_gnt_q.push_back(mk_gnt(0, 2'b01, 2'b00, 1, 0, 1, 1, CELL_HEAD));
      else            exp_gnt_q.push_back(mk_gnt(0, 2'b10, 2'b00, 1, 0, 2, 2, CELL_FOOD));
    end
    base = n_gnt; b0 = n_gnt0; b1 = n_gnt1;
    set_req(0, 1, 1, 1, CELL_HEAD);
    set_req(1, 1, 2, 2, CELL_FOOD);
    wait_gnts(base + 20, 60, "t3_gnt_timeout");
    bus.req = '0;
    check("fair_req0", n_gnt0 - b0, 10);
    check("fair_req1", n_gnt1 - b1, 10);
    repeat (2) tick();

    // blanking lock: write waits, read goes ahead; write follows vblank rise
    vblnk = 1'b0;
    exp_gnt_q.push_back(mk_gnt(1, 2'b10, 2'b00, 0, 1, 9, 10, CELL_FOOD));
    exp_rd_q.push_back(mk_rd(3, 2'b10, CELL_WALL));
    exp_gnt_q.push_back(mk_gnt(0, 2'b01, 2'b00, 1, 0, 7, 8, CELL_WALL));
    base = n_gnt;
    set_req(0, 1, 7, 8, CELL_WALL);
    set_req(1, 0, 9, 10, 0);
    wait_gnts(base + 1, 20, "t4_read_gnt_timeout");
    bus.req[1] = 1'b0;
    wait_read_done(20);
    repeat (4) tick();
    check("lock_holds_write", n_gnt, base + 1);
    vblnk = 1'b1;
    k = 0;
    while (n_gnt < base + 2 && k < 10) begin
      tick();
      k++;
    end
    check("vblank_release_latency", k, 1);
    bus.req[0] = 1'b0;
    repeat (2) tick();

    // out-of-range write then out-of-range read
    exp_gnt_q.push_back(mk_gnt(0, 2'b01, 2'b01, 0, 0, 7, 8, CELL_WALL));
    base = n_gnt;
    set_req(0, 1, 32, 0, CELL_HEAD);
    wait_gnts(base + 1, 20, "t5_wr_gnt_timeout");
    bus.req[0] = 1'b0;
    repeat (2) tick();
    exp_gnt_q.push_back(mk_gnt(1, 2'b10, 2'b10, 0, 0, 7, 8, CELL_WALL));
    exp_rd_q.push_back(mk_rd(1, 2'b10, CELL_EMPTY));
    base = n_gnt;
    set_req(1, 0, 0, 24, 0);
    wait_gnts(base + 1, 20, "t5_rd_gnt_timeout");
    bus.req[1] = 1'b0;
    wait_read_done(20);
    repeat (2) tick();

    // reset while waiting for read data; pointer returns to 0
    exp_gnt_q.push_back(mk_gnt(1, 2'b01, 2'b00, 0, 1, 5, 6, CELL_WALL));
    base = n_gnt;
    set_req(0, 0, 5, 6, 0);
    wait_gnts(base + 1, 20, "t6_rd_gnt_timeout");
    bus.req[0] = 1'b0;
    tick();
    check("in_rd_wait", dbg_state, ST_RD_WAIT);
    rst = 1'b0;
    #1;
    check_outputs_zero("reset_mid_read");
    repeat (2) tick();
    rst = 1'b1;
    repeat (8) tick();
    exp_gnt_q.push_back(mk_gnt(0, 2'b01, 2'b00, 1, 0, 1, 2, 4'd5));
    exp_gnt_q.push_back(mk_gnt(0, 2'b10, 2'b00, 1, 0, 3, 4, 4'd6));
    base = n_gnt;
    set_req(0, 1, 1, 2, 4'd5);
    set_req(1, 1, 3, 4, 4'd6);
    wait_gnts(base + 2, 20, "t6_wr_gnt_timeout");
    bus.req = '0;
    repeat (4) tick();

    check("gnt_queue_drained", exp_gnt_q.size(), 0);
    check("rd_queue_drained", exp_rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
